// File: rtl/pc_fetch.sv
// PC_FETCH: program counter and instruction fetch address sequencer.
// Optional perf counters are built when PC_FETCH_PERF_EN is defined.
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        iREN,
   output logic [31:0] imemaddr,
   output logic [31:0] PC,
   output logic [31:0] npc,
`ifdef PC_FETCH_PERF_EN
   output logic        flushed,
   output logic [31:0] fetch_count,
   output logic [31:0] flush_count
`else
   output logic        flushed
`endif
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      REDIR_PEND = 2'd1,
      HALTED     = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc_q;
   logic [31:0] pend_q;
   logic        active;
   logic        advance;
   logic [31:0] next_pc;

   // halt wins over everything, so it also suppresses the squash
   assign active  = (state != HALTED) && !halt;
   assign flushed = active && (redirect || state == REDIR_PEND);
   assign advance = active && ihit &&
                    (redirect || state == REDIR_PEND || !stall);

   always_comb begin
      next_pc = pc_q + 32'd4;
      if (redirect)
         next_pc = redirect_pc;
      else if (state == REDIR_PEND)
         next_pc = pend_q;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= RUN;
         pc_q   <= RESET_PC;
         pend_q <= 32'h0;
      end else if (active) begin
         if (advance) begin
            pc_q  <= next_pc;
            state <= RUN;
         end else if (redirect) begin
            pend_q <= redirect_pc;
            state  <= REDIR_PEND;
         end
      end else if (halt) begin
         state <= HALTED;
      end
   end

`ifdef PC_FETCH_PERF_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         fetch_count <= 32'h0;
         flush_count <= 32'h0;
      end else begin
         if (advance)
            fetch_count <= fetch_count + 32'd1;
         if (flushed && ihit)
            flush_count <= flush_count + 32'd1;
      end
   end
`endif

   assign iREN     = (state != HALTED);
   assign PC       = pc_q;
   assign imemaddr = pc_q;
   assign npc      = pc_q + 32'd4;

endmodule
